// File: rtl/alu_ex_stage_if.sv
// ALU opcode encodings and the execute-stage handshake interface.
// master drives the ops and consumes results; slave is the ALU stage.
package alu_ex_pkg;
   localparam logic [3:0] ALU_ADD    = 4'd0;
   localparam logic [3:0] ALU_SUB    = 4'd1;
   localparam logic [3:0] ALU_AND    = 4'd2;
   localparam logic [3:0] ALU_OR     = 4'd3;
   localparam logic [3:0] ALU_XOR    = 4'd4;
   localparam logic [3:0] ALU_SLT    = 4'd5;
   localparam logic [3:0] ALU_SLTU   = 4'd6;
   localparam logic [3:0] ALU_SLL    = 4'd7;
   localparam logic [3:0] ALU_SRA    = 4'd8;
   localparam logic [3:0] ALU_SRL    = 4'd9;
   localparam logic [3:0] ALU_COPY_B = 4'd10;
   localparam logic [3:0] ALU_XXX    = 4'd15;
endpackage

interface alu_ex_stage_if #(
   parameter int DWIDTH = 32
);
   logic              flush;
   logic              in_valid;
   logic              in_ready;
   logic [3:0]        alu_op;
   logic [DWIDTH-1:0] op_a;
   logic [DWIDTH-1:0] op_b;
   logic [4:0]        rd_in;
   logic              out_valid;
   logic              out_ready;
   logic [DWIDTH-1:0] result;
   logic [4:0]        rd_out;
   logic              busy;

   modport master (
      output flush, in_valid, alu_op, op_a, op_b, rd_in, out_ready,
      input  in_ready, out_valid, result, rd_out, busy
   );

   modport slave (
      input  flush, in_valid, alu_op, op_a, op_b, rd_in, out_ready,
      output in_ready, out_valid, result, rd_out, busy
   );
endinterface

// File: rtl/alu_ex_stage.sv
// Registered execute-stage ALU with a one-entry output register.
// Define ALU_SERIAL_SHIFT_EN for 1-bit-per-cycle shifts instead of a barrel.
module alu_ex_stage
   import alu_ex_pkg::*;
#(
   parameter int DWIDTH = 32
) (
   input logic          clk,
   input logic          rst,
   alu_ex_stage_if.slave io
);

   function automatic logic [DWIDTH-1:0] alu_calc(
      input logic [3:0]        op,
      input logic [DWIDTH-1:0] a,
      input logic [DWIDTH-1:0] b
   );
      logic [DWIDTH-1:0] r;
      r = '0;
      unique case (op)
         ALU_ADD:    r = a + b;
         ALU_SUB:    r = a - b;
         ALU_AND:    r = a & b;
         ALU_OR:     r = a | b;
         ALU_XOR:    r = a ^ b;
         ALU_SLT:    r = {{(DWIDTH-1){1'b0}}, $signed(a) < $signed(b)};
         ALU_SLTU:   r = {{(DWIDTH-1){1'b0}}, a < b};
         ALU_COPY_B: r = b;
`ifdef ALU_SERIAL_SHIFT_EN
         // only reached with a zero shift amount
         ALU_SLL,
         ALU_SRL,
         ALU_SRA:    r = a;
`else
         ALU_SLL:    r = a << b[4:0];
         ALU_SRL:    r = a >> b[4:0];
         ALU_SRA:    r = $unsigned($signed(a) >>> b[4:0]);
`endif
         default:    r = '0;
      endcase
      return r;
   endfunction

   logic              out_vld_q;
   logic              out_vld_d;
   logic [DWIDTH-1:0] res_q;
   logic [DWIDTH-1:0] res_d;
   logic [4:0]        rd_q;
   logic [4:0]        rd_d;
   logic              accept;
   logic [DWIDTH-1:0] alu_res;

   assign alu_res      = alu_calc(io.alu_op, io.op_a, io.op_b);
   assign accept       = io.in_valid && io.in_ready;
   assign io.out_valid = out_vld_q;
   assign io.result    = res_q;
   assign io.rd_out    = rd_q;

`ifdef ALU_SERIAL_SHIFT_EN
   function automatic logic [DWIDTH-1:0] shift1(
      input logic [3:0]        op,
      input logic [DWIDTH-1:0] v
   );
      logic [DWIDTH-1:0] r;
      unique case (op)
         ALU_SLL: r = {v[DWIDTH-2:0], 1'b0};
         ALU_SRA: r = {v[DWIDTH-1], v[DWIDTH-1:1]};
         default: r = {1'b0, v[DWIDTH-1:1]};
      endcase
      return r;
   endfunction

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t            state_q;
   state_t            state_d;
   logic [4:0]        cnt_q;
   logic [4:0]        cnt_d;
   logic [DWIDTH-1:0] acc_q;
   logic [DWIDTH-1:0] acc_d;
   logic [DWIDTH-1:0] acc_sh;
   logic [4:0]        tag_q;
   logic [4:0]        tag_d;
   logic [3:0]        sop_q;
   logic [3:0]        sop_d;
   logic [4:0]        shamt;
   logic              is_shift;

   assign shamt    = io.op_b[4:0];
   assign is_shift = (io.alu_op == ALU_SLL) ||
                     (io.alu_op == ALU_SRL) ||
                     (io.alu_op == ALU_SRA);
   assign acc_sh   = shift1(sop_q, acc_q);

   assign io.in_ready = (state_q == IDLE) && !io.flush &&
                        (!out_vld_q || io.out_ready);
   assign io.busy     = (state_q == SHIFT);

   // next state, shift datapath and output register load
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      tag_d     = tag_q;
      sop_d     = sop_q;
      out_vld_d = out_vld_q;
      res_d     = res_q;
      rd_d      = rd_q;
      if (io.flush) begin
         state_d   = IDLE;
         cnt_d     = '0;
         out_vld_d = 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (out_vld_q && io.out_ready)
                  out_vld_d = 1'b0;
               if (accept) begin
                  if (is_shift && shamt != 5'd0) begin
                     state_d = SHIFT;
                     acc_d   = io.op_a;
                     cnt_d   = shamt;
                     tag_d   = io.rd_in;
                     sop_d   = io.alu_op;
                  end else begin
                     res_d     = alu_res;
                     rd_d      = io.rd_in;
                     out_vld_d = 1'b1;
                  end
               end
            end
            SHIFT: begin
               acc_d = acc_sh;
               cnt_d = cnt_q - 5'd1;
               if (cnt_q == 5'd1) begin
                  state_d   = IDLE;
                  res_d     = acc_sh;
                  rd_d      = tag_q;
                  out_vld_d = 1'b1;
               end
            end
         endcase
      end
   end

   // shift sequencer registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         acc_q   <= '0;
         tag_q   <= '0;
         sop_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         tag_q   <= tag_d;
         sop_q   <= sop_d;
      end
   end
`else
   assign io.in_ready = !io.flush && (!out_vld_q || io.out_ready);
   assign io.busy     = 1'b0;

   // output register load, drain and kill
   always_comb begin
      out_vld_d = out_vld_q;
      res_d     = res_q;
      rd_d      = rd_q;
      if (io.flush) begin
         out_vld_d = 1'b0;
      end else begin
         if (out_vld_q && io.out_ready)
            out_vld_d = 1'b0;
         if (accept) begin
            res_d     = alu_res;
            rd_d      = io.rd_in;
            out_vld_d = 1'b1;
         end
      end
   end
`endif

   // one-entry output register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_vld_q <= 1'b0;
         res_q     <= '0;
         rd_q      <= '0;
      end else begin
         out_vld_q <= out_vld_d;
         res_q     <= res_d;
         rd_q      <= rd_d;
      end
   end

endmodule

// File: tb/tb_alu_ex_stage.sv
// Testbench for alu_ex_stage: directed cases plus randomized traffic,
// checked every cycle against a transaction-level model.
module tb_alu_ex_stage;
   import alu_ex_pkg::*;

`ifdef ALU_SERIAL_SHIFT_EN
   localparam bit SERIAL = 1'b1;
`else
   localparam bit SERIAL = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_fail = 0;

   alu_ex_stage_if #(.DWIDTH(32)) bus ();

   alu_ex_stage #(.DWIDTH(32)) dut (
      .clk (clk),
      .rst (rst),
      .io  (bus.slave)
   );

   always #5 clk = ~clk;

   // model state: output register plus a pending result
   // that matures after the shift amount worth of cycles
   logic        m_vld = 1'b0;
   logic [31:0] m_res = '0;
   logic [4:0]  m_rd = '0;
   int          m_cnt = 0;
   logic [31:0] m_pres = '0;
   logic [4:0]  m_ptag = '0;

   function automatic logic [31:0] ref_alu(
      input logic [3:0]  op,
      input logic [31:0] a,
      input logic [31:0] b
   );
      int sh;
      sh = int'(b[4:0]);
      case (op)
         ALU_ADD:    return a + b;
         ALU_SUB:    return a - b;
         ALU_AND:    return a & b;
         ALU_OR:     return a | b;
         ALU_XOR:    return a ^ b;
         ALU_SLT:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         ALU_SLTU:   return (a < b) ? 32'd1 : 32'd0;
         ALU_SLL:    return a << sh;
         ALU_SRL:    return a >> sh;
         ALU_SRA:    return $unsigned($signed(a) >>> sh);
         ALU_COPY_B: return b;
         default:    return 32'd0;
      endcase
   endfunction

   function automatic bit is_shift(input logic [3:0] op);
      return op == ALU_SLL || op == ALU_SRL || op == ALU_SRA;
   endfunction

   function automatic logic exp_ready();
      return (m_cnt == 0) && !bus.flush && (!m_vld || bus.out_ready);
   endfunction

   task automatic chk(input string nm,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t",
                  nm, act, exp, $time);
      end
   endtask

   // model update at each edge
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_vld <= 1'b0;
         m_res <= '0;
         m_rd  <= '0;
         m_cnt <= 0;
      end else if (bus.flush) begin
         m_vld <= 1'b0;
         m_cnt <= 0;
      end else if (m_cnt != 0) begin
         m_cnt <= m_cnt - 1;
         if (m_cnt == 1) begin
            m_vld <= 1'b1;
            m_res <= m_pres;
            m_rd  <= m_ptag;
         end
      end else begin
         if (m_vld && bus.out_ready)
            m_vld <= 1'b0;
         if (bus.in_valid && exp_ready()) begin
            if (SERIAL && is_shift(bus.alu_op) && bus.op_b[4:0] != 5'd0) begin
               m_cnt  <= int'(bus.op_b[4:0]);
               m_pres <= ref_alu(bus.alu_op, bus.op_a, bus.op_b);
               m_ptag <= bus.rd_in;
               m_vld  <= 1'b0;
            end else begin
               m_vld <= 1'b1;
               m_res <= ref_alu(bus.alu_op, bus.op_a, bus.op_b);
               m_rd  <= bus.rd_in;
            end
         end
      end
   end

   // compare DUT against model every cycle
   always @(negedge clk) begin
      chk("in_ready", {31'd0, bus.in_ready}, {31'd0, exp_ready()});
      chk("out_valid", {31'd0, bus.out_valid}, {31'd0, m_vld});
      chk("busy", {31'd0, bus.busy}, {31'd0, m_cnt != 0});
      if (m_vld) begin
         chk("result", bus.result, m_res);
         chk("rd_out", {27'd0, bus.rd_out}, {27'd0, m_rd});
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic offer(input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd);
      bus.in_valid = 1'b1;
      bus.alu_op   = op;
      bus.op_a     = a;
      bus.op_b     = b;
      bus.rd_in    = rd;
      cyc();
      bus.in_valid = 1'b0;
      #1;
   endtask

   initial begin
      logic [31:0] ea;
      logic [31:0] eb;
      bus.flush     = 1'b0;
      bus.in_valid  = 1'b0;
      bus.alu_op    = ALU_ADD;
      bus.op_a      = '0;
      bus.op_b      = '0;
      bus.rd_in     = '0;
      bus.out_ready = 1'b1;
      repeat (3) cyc();
      rst = 1'b0;
      #1;
      chk("init_in_ready", {31'd0, bus.in_ready}, 32'd1);
      chk("init_out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("init_result", bus.result, 32'd0);

      offer(ALU_SUB, 32'h0, 32'h1, 5'd5);
      chk("sub_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("sub_result", bus.result, 32'hFFFF_FFFF);
      chk("sub_rd", {27'd0, bus.rd_out}, 32'd5);
      offer(ALU_SLT, 32'hFFFF_FFFF, 32'h1, 5'd6);
      chk("slt_result", bus.result, 32'd1);
      offer(ALU_SLTU, 32'hFFFF_FFFF, 32'h1, 5'd7);
      chk("sltu_result", bus.result, 32'd0);
      offer(ALU_XXX, 32'h1234_5678, 32'h1, 5'd8);
      chk("xxx_result", bus.result, 32'd0);
      chk("xxx_rd", {27'd0, bus.rd_out}, 32'd8);
      cyc();

      bus.out_ready = 1'b0;
      offer(ALU_ADD, 32'd1, 32'd2, 5'd1);
      chk("bp_first", bus.result, 32'd3);
      bus.in_valid = 1'b1;
      bus.op_a     = 32'd10;
      bus.op_b     = 32'd20;
      bus.rd_in    = 5'd2;
      #1;
      chk("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
      cyc();
      chk("bp_hold_res", bus.result, 32'd3);
      chk("bp_hold_rd", {27'd0, bus.rd_out}, 32'd1);
      cyc();
      chk("bp_hold_res2", bus.result, 32'd3);
      bus.out_ready = 1'b1;
      #1;
      chk("bp_release_ready", {31'd0, bus.in_ready}, 32'd1);
      cyc();
      bus.in_valid = 1'b0;
      chk("bp_second_res", bus.result, 32'd30);
      chk("bp_second_rd", {27'd0, bus.rd_out}, 32'd2);
      cyc();

      offer(ALU_SRA, 32'h8000_0000, 32'd4, 5'd7);
      if (SERIAL) begin
         for (int k = 0; k < 4; k++) begin
            chk("sra_busy", {31'd0, bus.busy}, 32'd1);
            chk("sra_in_ready", {31'd0, bus.in_ready}, 32'd0);
            cyc();
         end
      end
      chk("sra_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("sra_result", bus.result, 32'hF800_0000);
      chk("sra_busy_done", {31'd0, bus.busy}, 32'd0);
      offer(ALU_SRA, 32'h8000_0000, 32'd0, 5'd8);
      chk("sra0_result", bus.result, 32'h8000_0000);
      cyc();

      offer(ALU_SRL, 32'hFFFF_0000, 32'd4, 5'd9);
      cyc();
      cyc();
      bus.flush = 1'b1;
      cyc();
      bus.flush = 1'b0;
      chk("fl_busy", {31'd0, bus.busy}, 32'd0);
      for (int k = 0; k < 6; k++) begin
         chk("fl_no_result", {31'd0, bus.out_valid}, 32'd0);
         cyc();
      end

      bus.out_ready = 1'b0;
      offer(ALU_ADD, 32'd5, 32'd6, 5'd3);
      chk("fl2_valid", {31'd0, bus.out_valid}, 32'd1);
      bus.in_valid = 1'b1;
      bus.op_a     = 32'd7;
      bus.op_b     = 32'd8;
      bus.rd_in    = 5'd4;
      bus.flush    = 1'b1;
      #1;
      chk("fl2_in_ready", {31'd0, bus.in_ready}, 32'd0);
      cyc();
      bus.flush    = 1'b0;
      bus.in_valid = 1'b0;
      chk("fl2_cleared", {31'd0, bus.out_valid}, 32'd0);
      cyc();
      chk("fl2_not_taken", {31'd0, bus.out_valid}, 32'd0);
      bus.out_ready = 1'b1;

      bus.in_valid = 1'b1;
      bus.alu_op   = ALU_ADD;
      for (int i = 0; i < 8; i++) begin
         ea = 32'(i) * 32'h1111_1111;
         eb = 32'h0F0F_0F0F + 32'(i);
         bus.op_a  = ea;
         bus.op_b  = eb;
         bus.rd_in = 5'(i + 10);
         cyc();
         chk("tp_valid", {31'd0, bus.out_valid}, 32'd1);
         chk("tp_result", bus.result, ea + eb);
         chk("tp_rd", {27'd0, bus.rd_out}, 32'(i + 10));
      end
      bus.in_valid = 1'b0;
      cyc();

      offer(ALU_SLL, 32'd1, 32'd20, 5'd11);
      cyc();
      rst = 1'b1;
      #1;
      chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("rst_result", bus.result, 32'd0);
      chk("rst_rd", {27'd0, bus.rd_out}, 32'd0);
      chk("rst_busy", {31'd0, bus.busy}, 32'd0);
      cyc();
      rst = 1'b0;
      #1;
      chk("post_rst_ready", {31'd0, bus.in_ready}, 32'd1);
      chk("post_rst_valid", {31'd0, bus.out_valid}, 32'd0);

      for (int i = 0; i < 3000; i++) begin
         bus.in_valid  = $urandom_range(0, 3) != 0;
         bus.alu_op    = 4'($urandom_range(0, 15));
         bus.op_a      = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
         bus.op_b      = ($urandom_range(0, 1) == 1) ? $urandom
                                                     : 32'($urandom_range(0, 40));
         bus.rd_in     = 5'($urandom_range(0, 31));
         bus.out_ready = $urandom_range(0, 3) != 0;
         bus.flush     = $urandom_range(0, 40) == 0;
         cyc();
      end
      bus.in_valid  = 1'b0;
      bus.flush     = 1'b0;
      bus.out_ready = 1'b1;
      repeat (40) cyc();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
